// File: rtl/bp_run_ctrl.sv
// Run-control / breakpoint-match unit: gates the CPU and halts it after a breakpoint, step or stop.
// Latency: commands and retires sampled at edge k are reflected on every output in cycle k+1.
// Backpressure: none; the CPU is throttled through cpu_en and the list is popped with reach_bp.
module bp_run_ctrl #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  input  logic             stop,
  input  logic             cnt_clr,
  input  logic [PC_W-1:0]  bp_0,
  input  logic [PC_W-1:0]  bp_1,
  input  logic [PC_W-1:0]  bp_2,
  input  logic [2:0]       bp_valid,
  input  logic             commit,
  input  logic [PC_W-1:0]  commit_pc,
  output logic             cpu_en,
  output logic             reach_bp,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [PC_W-1:0]  halt_pc,
  output logic [CNT_W-1:0] commit_cnt
);

  typedef enum logic [1:0] {
    S_HALTED = 2'd0,
    S_RUN    = 2'd1,
    S_STEP   = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_BP   = 2'b01;
  localparam logic [1:0] CAUSE_STEP = 2'b10;
  localparam logic [1:0] CAUSE_STOP = 2'b11;

  state_t     state_q;
  state_t     state_d;
  logic [1:0] cause_d;
  logic       pop_d;
  logic       obs;
  logic       hit;

  // Later list entries only matter once they shift into bp_0.
  logic unused_list;
  assign unused_list = ^{bp_1, bp_2, bp_valid[2:1]};

  // A retire only counts while the CPU is enabled; only the list head is compared.
  assign obs = cpu_en & commit;
  assign hit = obs & bp_valid[0] & (commit_pc == bp_0);

  // Next-state, next halt cause and pop request; a hit outranks every other halt reason.
  always_comb begin
    state_d = state_q;
    cause_d = halt_cause;
    pop_d   = 1'b0;
    case (state_q)
      S_HALTED: begin
        if (stop) begin
          state_d = S_HALTED;
        end else if (run) begin
          state_d = S_RUN;
        end else if (step) begin
          state_d = S_STEP;
        end
      end
      S_RUN: begin
        if (hit) begin
          state_d = S_HALTED;
          cause_d = CAUSE_BP;
          pop_d   = 1'b1;
        end else if (stop) begin
          state_d = S_HALTED;
          cause_d = CAUSE_STOP;
        end
      end
      S_STEP: begin
        if (hit) begin
          state_d = S_HALTED;
          cause_d = CAUSE_BP;
          pop_d   = 1'b1;
        end else if (obs) begin
          state_d = S_HALTED;
          cause_d = CAUSE_STEP;
        end else if (stop) begin
          state_d = S_HALTED;
          cause_d = CAUSE_STOP;
        end
      end
      default: begin
        state_d = S_HALTED;
      end
    endcase
  end

  // State and all outputs registered; enable/halted decoded from the next state so they stay in step.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_HALTED;
      cpu_en     <= 1'b0;
      halted     <= 1'b1;
      reach_bp   <= 1'b0;
      halt_cause <= CAUSE_NONE;
      halt_pc    <= '0;
      commit_cnt <= '0;
    end else begin
      state_q    <= state_d;
      cpu_en     <= (state_d != S_HALTED);
      halted     <= (state_d == S_HALTED);
      reach_bp   <= pop_d;
      halt_cause <= cause_d;
      if (obs) begin
        halt_pc <= commit_pc;
      end
      if (cnt_clr) begin
        commit_cnt <= '0;
      end else if (obs) begin
        commit_cnt <= commit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bp_run_ctrl.sv
// Testbench for bp_run_ctrl: directed scenarios then random traffic against a behavioural model.
// Expected outputs are queued by the driver; a monitor pops and compares one entry per cycle.
// A narrow retire counter keeps the wrap-around scenario short.
module tb_bp_run_ctrl;

  localparam int PC_W  = 32;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             run = 1'b0;
  logic             step = 1'b0;
  logic             stop = 1'b0;
  logic             cnt_clr = 1'b0;
  logic [PC_W-1:0]  bp_0 = '0;
  logic [PC_W-1:0]  bp_1 = '0;
  logic [PC_W-1:0]  bp_2 = '0;
  logic [2:0]       bp_valid = '0;
  logic             commit = 1'b0;
  logic [PC_W-1:0]  commit_pc = '0;
  logic             cpu_en;
  logic             reach_bp;
  logic             halted;
  logic [1:0]       halt_cause;
  logic [PC_W-1:0]  halt_pc;
  logic [CNT_W-1:0] commit_cnt;

  bp_run_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .run(run), .step(step), .stop(stop), .cnt_clr(cnt_clr),
    .bp_0(bp_0), .bp_1(bp_1), .bp_2(bp_2), .bp_valid(bp_valid),
    .commit(commit), .commit_pc(commit_pc),
    .cpu_en(cpu_en), .reach_bp(reach_bp), .halted(halted), .halt_cause(halt_cause),
    .halt_pc(halt_pc), .commit_cnt(commit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             cpu_en;
    logic             reach_bp;
    logic             halted;
    logic [1:0]       cause;
    logic [PC_W-1:0]  hpc;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   dut_pops = 0;

  // Reference model: mode 0 = halted, 1 = free-running, 2 = single-stepping.
  int              m_mode = 0;
  int              m_cause = 0;
  logic [PC_W-1:0] m_hpc = '0;
  int              m_cnt = 0;
  logic [PC_W-1:0] bp_list[$];
  logic [PC_W-1:0] ghost_pc = '0;

  task automatic check(input string name, input logic [PC_W-1:0] act, input logic [PC_W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
    end
  endtask

  // Monitor: each cycle, compare the DUT outputs against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reach_bp === 1'b1) dut_pops++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cpu_en",     PC_W'(cpu_en),     PC_W'(e.cpu_en));
        check("reach_bp",   PC_W'(reach_bp),   PC_W'(e.reach_bp));
        check("halted",     PC_W'(halted),     PC_W'(e.halted));
        check("halt_cause", PC_W'(halt_cause), PC_W'(e.cause));
        check("halt_pc",    halt_pc,           e.hpc);
        check("commit_cnt", PC_W'(commit_cnt), PC_W'(e.cnt));
      end
    end
  end

  // Drive one cycle of inputs, advance the model by the same edge and queue what must follow.
  task automatic drive(input bit r, input bit s, input bit sp, input bit clr,
                       input bit cm, input logic [PC_W-1:0] pc, input bit rs);
    bit   en, obs, hit, pop;
    exp_t e;
    @(negedge clk);
    rst = rs; run = r; step = s; stop = sp; cnt_clr = clr; commit = cm; commit_pc = pc;
    bp_0 = (bp_list.size() > 0) ? bp_list[0] : ghost_pc;
    bp_1 = (bp_list.size() > 1) ? bp_list[1] : '0;
    bp_2 = (bp_list.size() > 2) ? bp_list[2] : '0;
    bp_valid = {bp_list.size() > 2, bp_list.size() > 1, bp_list.size() > 0};
    pop = 1'b0;
    if (rs) begin
      m_mode = 0; m_cause = 0; m_hpc = '0; m_cnt = 0;
    end else begin
      en  = (m_mode != 0);
      obs = en && cm;
      hit = obs && (bp_list.size() > 0) && (pc == bp_list[0]);
      if (m_mode == 0) begin
        if (!sp && r) m_mode = 1;
        else if (!sp && s) m_mode = 2;
      end else if (hit) begin
        m_mode = 0; m_cause = 1; pop = 1'b1;
      end else if (m_mode == 2 && obs) begin
        m_mode = 0; m_cause = 2;
      end else if (sp) begin
        m_mode = 0; m_cause = 3;
      end
      if (obs) m_hpc = pc;
      if (clr) m_cnt = 0;
      else if (obs) m_cnt = (m_cnt + 1) % (1 << CNT_W);
      if (pop) void'(bp_list.pop_front());
    end
    e.cpu_en   = (m_mode != 0);
    e.reach_bp = pop;
    e.halted   = (m_mode == 0);
    e.cause    = 2'(m_cause);
    e.hpc      = m_hpc;
    e.cnt      = CNT_W'(m_cnt);
    exp_q.push_back(e);
  endtask

  task automatic idle();          drive(0, 0, 0, 0, 0, '0, 0); endtask
  task automatic do_run();        drive(1, 0, 0, 0, 0, '0, 0); endtask
  task automatic do_step();       drive(0, 1, 0, 0, 0, '0, 0); endtask
  task automatic do_stop();       drive(0, 0, 1, 0, 0, '0, 0); endtask
  task automatic retire(input logic [PC_W-1:0] pc); drive(0, 0, 0, 0, 1, pc, 0); endtask

  initial begin
    int pops_before;
    logic [PC_W-1:0] pc;

    // Reset and first breakpoint at 0x08.
    drive(0, 0, 0, 0, 0, '0, 1);
    drive(0, 0, 0, 0, 0, '0, 1);
    idle();
    bp_list = '{32'h08};
    do_run();
    retire(32'h00); retire(32'h04); retire(32'h08);
    idle(); idle();

    // Two breakpoints consumed in order: exactly two pops.
    pops_before = dut_pops;
    bp_list = '{32'h10, 32'h20};
    do_run();
    retire(32'h0C); retire(32'h10);
    idle(); idle();
    do_run();
    for (int a = 32'h14; a <= 32'h20; a += 4) retire(a);
    idle(); idle();
    check("two_pops", PC_W'(dut_pops - pops_before), 32'd2);

    // Single step, without then with a matching breakpoint.
    do_step(); retire(32'h40); idle();
    bp_list = '{32'h40};
    do_step(); retire(32'h40); idle(); idle();

    // stop together with a hit, plain stop, and stop+run while halted.
    bp_list = '{32'h0C};
    do_run(); drive(0, 0, 1, 0, 1, 32'h0C, 0); idle(); idle();
    do_run(); idle(); do_stop(); idle();
    drive(1, 0, 1, 0, 0, '0, 0); idle();

    // Empty list never halts; retires while halted are ignored; compare uses all PC bits.
    ghost_pc = 32'h08;
    do_run(); retire(32'h08); idle(); do_stop();
    retire(32'h99); idle();
    bp_list = '{32'h8000_0008};
    do_run(); retire(32'h08); do_stop(); idle();
    bp_list.delete();

    // Counter wrap, clear beating a retire, then reset mid-run with a pending hit.
    ghost_pc = 32'hFFFF_FFF0;
    drive(0, 0, 0, 1, 0, '0, 0);
    do_run();
    for (int i = 0; i < (1 << CNT_W) - 1; i++) retire(32'h1000 + 4 * i);
    retire(32'h2000);
    retire(32'h2004);
    drive(0, 0, 0, 1, 1, 32'h2008, 0);
    bp_list = '{32'h200C};
    drive(0, 0, 0, 0, 1, 32'h200C, 1);
    idle(); idle();
    bp_list.delete();

    // Random traffic with breakpoints placed ahead of the retire PC.
    pc = 32'h4000;
    for (int i = 0; i < 3000; i++) begin
      bit r, s, sp, clr, cm, rs;
      if (bp_list.size() == 0 && $urandom_range(0, 3) == 0) begin
        logic [PC_W-1:0] nb = pc;
        for (int k = 0; k < 3; k++) begin
          nb = nb + 4 * $urandom_range(1, 12);
          bp_list.push_back(nb);
        end
      end
      r   = ($urandom_range(0, 9) == 0);
      s   = ($urandom_range(0, 11) == 0);
      sp  = ($urandom_range(0, 29) == 0);
      clr = ($urandom_range(0, 49) == 0);
      cm  = ($urandom_range(0, 1) == 1);
      rs  = ($urandom_range(0, 299) == 0);
      drive(r, s, sp, clr, cm, pc, rs);
      if (cm && m_mode != 0) pc = pc + 4;
      if (bp_list.size() > 0 && bp_list[0] < pc) void'(bp_list.pop_front());
    end

    idle(); idle();
    @(posedge clk);
    #3;
    check("queue_drained", PC_W'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bp_run_ctrl.md
# bp_run_ctrl

Run-control and breakpoint-match unit of the PDU. It consumes the ordered breakpoint list (head entry `bp_0`, plus its valid bits) and watches the CPU's retire stream. It gates the CPU through a global enable, halts the CPU after a breakpoint instruction retires, and returns a one-cycle `reach_bp` pop to the list. It also implements run, single-step and stop commands, and keeps retire statistics for the debug front end.

## Interface
Parameters:
- `PC_W`, default 32: width of PCs and breakpoint addresses.
- `CNT_W`, default 32: width of the retire counter.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset: synchronous, active-high.
- `run`  in  1  one-cycle command: free-run until breakpoint or stop.
- `step`  in  1  one-cycle command: retire exactly one instruction, then halt.
- `stop`  in  1  one-cycle command: halt.
- `cnt_clr`  in  1  clear `commit_cnt`.
- `bp_0` / `bp_1` / `bp_2`  in  PC_W each  breakpoint list entries. Only `bp_0` is compared, because breakpoints are consumed in order.
- `bp_valid`  in  3  list valid bits. `bp_valid[0]` qualifies `bp_0`.
- `commit`  in  1  CPU retires an instruction this cycle.
- `commit_pc`  in  PC_W  PC of the retiring instruction.
- `cpu_en`  out  1  registered global CPU enable.
- `reach_bp`  out  1  registered one-cycle pop strobe to the breakpoint list.
- `halted`  out  1  high in state HALTED.
- `halt_cause`  out  2  cause of the last halt: 00 none, 01 breakpoint, 10 step, 11 stop.
- `halt_pc`  out  PC_W  PC of the last observed retire.
- `commit_cnt`  out  CNT_W  observed retires since reset or the last clear.

## Operation
- States: HALTED (entered on reset), RUN, STEP. `cpu_en` = 1 exactly in RUN and STEP. `halted` = 1 exactly in HALTED.
- Observed retire `obs` = `cpu_en & commit`. Any `commit` while `cpu_en` = 0 is ignored entirely.
- Match `hit` = `obs & bp_valid[0] & (commit_pc == bp_0)`. The full PC_W compare is exact.
- HALTED:
  - `stop` → stay in HALTED.
  - else `run` → RUN.
  - else `step` → STEP.
  - Priority is stop > run > step. `halt_cause` holds its value when leaving HALTED.
- RUN:
  - `hit` → HALTED, cause 01.
  - else `stop` → HALTED, cause 11.
  - `run` and `step` are ignored.
- STEP:
  - `hit` → HALTED, cause 01.
  - else `obs` → HALTED, cause 10.
  - else `stop` → HALTED, cause 11.
  - `run` and `step` are ignored.
- On every transition to HALTED caused by `hit`, `reach_bp` = 1 for exactly the next cycle, and 0 at all other times. A pop is therefore never issued while `bp_valid[0]` = 0, and at most one pop is issued per halt.
- The breakpoint instruction itself retires; the halt takes effect after it. Issuing `run` again continues with the new head entry (the former `bp_1`).
- On `obs`: `halt_pc` ← `commit_pc`, and `commit_cnt` ← `commit_cnt` + 1, wrapping modulo 2^CNT_W.
- `cnt_clr` sets `commit_cnt` to 0. When `cnt_clr` and `obs` occur in the same cycle, the clear wins and the result is 0. `cnt_clr` does not affect `halt_pc`.

## Timing
- All outputs are registered.
- Reset values: state HALTED, `cpu_en` 0, `reach_bp` 0, `halted` 1, `halt_cause` 00, `halt_pc` 0, `commit_cnt` 0.
- Reset mid-RUN or mid-STEP: after the reset edge, all outputs are at their reset values. A `hit` in the reset cycle produces no `reach_bp`.
- A command sampled at edge k takes effect after edge k, so `cpu_en` = 1 in cycle k+1.
- A `hit` sampled at edge k gives `cpu_en` = 0, `halted` = 1 and `reach_bp` = 1 in cycle k+1, and `reach_bp` = 0 in cycle k+2.
- Exactly one instruction (the matching one) retires with `cpu_en` high in the halting cycle. None retires after it.
- `stop` and `hit` in the same cycle: cause 01, `reach_bp` pulses.
- Step whose retire matches: cause 01 with a pop, not cause 10.
- `bp_valid` = 000: never halts on a breakpoint, and `reach_bp` stays 0.

## Test plan
- Reset, then `run`; retire PCs 0x00, 0x04, 0x08 with `bp_0` = 0x08 and `bp_valid` = 001 → `cpu_en` is 0 and `reach_bp` is 1 in the cycle after the 0x08 retire; `halt_cause` = 01, `halt_pc` = 0x08, `commit_cnt` = 3.
- `bp_0` = 0x10, `bp_1` = 0x20, `bp_valid` = 011; `run`; retire through 0x10 → halt with one pop. Model the list shift, then `run` → halt after 0x20 with a second pop. Exactly 2 pulses in total.
- Halted; pulse `step` and retire 0x40 (not a breakpoint) → cause 10, `halt_pc` = 0x40, `commit_cnt` +1, `reach_bp` never asserted. Repeat with `bp_0` = 0x40 and `bp_valid` = 001 → cause 01 and one pop.
- RUN; assert `stop` in the same cycle as the retire of a matching PC 0x0C → cause 01 with a pop. Separately, `stop` with no retire → cause 11 with no pop. In HALTED, `stop` + `run` together → stays HALTED.
- `bp_valid` = 000 and `bp_0` = 0x08; `run`; retire 0x08 → no halt, `reach_bp` stays 0. Then `commit` while halted → `commit_cnt` and `halt_pc` are unchanged.
- `commit_cnt` preset to 0xFFFFFFFF via retires; one more retire → 0. Then `cnt_clr` together with a retire → 0. Finally `rst` mid-RUN → all outputs at their reset values.
